// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: round-robin APB master that reprograms one PTC channel per accepted request.
// Latency: grant at T, six SETUP/ACCESS pairs T+1..T+12, done_valid at T+13 (illegal channel: T+1).
// Backpressure: req_ready pulses only in IDLE; requesters hold req_valid and fields until accepted.
//
// Ports:
//   PCLK / PRESET              clock, synchronous active-high reset
//   req_valid/req_ready        per-requester handshake, req_ready is a one-hot accept strobe
//   req_ch/load/period/con     per-requester channel and register values (slice i = requester i)
//   done_valid/id/err, busy    completion pulse, requester index, error flag, sequence in progress
//   PSELPTC..PWDATA, PRDATA    APB master port to the PWM block (no PREADY, no wait states)
module pwm_cfg_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int NUM_CH  = 6
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_ch,
  input  logic [32*NUM_REQ-1:0] req_load,
  input  logic [32*NUM_REQ-1:0] req_period,
  input  logic [16*NUM_REQ-1:0] req_con,
  output logic                  done_valid,
  output logic [1:0]            done_id,
  output logic                  done_err,
  output logic                  busy,
  output logic                  PSELPTC,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [6:0]            PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_CON    = 2'd3;

  localparam logic [2:0] LAST_STEP = 3'd5;

  logic [1:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [2:0]  ch_q, ch_d;
  logic [31:0] load_q, load_d;
  logic [31:0] period_q, period_d;
  logic [15:0] con_q, con_d;
  logic        err_q, err_d;

  // Upper half of the CON readback carries nothing we compare.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^PRDATA[31:16];

  // Distance of requester idx from the slot just after the last grant.
  function automatic int rr_dist(input int idx, input logic [1:0] ptr);
    return (idx + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
  endfunction

  logic               gnt_any;
  logic [1:0]         gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  int                 gnt_dist;
  logic [2:0]         sel_ch;
  logic [31:0]        sel_load;
  logic [31:0]        sel_period;
  logic [15:0]        sel_con;
  logic               sel_illegal;

  // Round-robin pick: the valid requester closest after the pointer wins.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_oh     = '0;
    gnt_dist   = NUM_REQ;
    sel_ch     = '0;
    sel_load   = '0;
    sel_period = '0;
    sel_con    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (rr_dist(i, rr_q) < gnt_dist)) begin
        gnt_any    = 1'b1;
        gnt_dist   = rr_dist(i, rr_q);
        gnt_idx    = 2'(i);
        gnt_oh     = '0;
        gnt_oh[i]  = 1'b1;
        sel_ch     = req_ch[3*i +: 3];
        sel_load   = req_load[32*i +: 32];
        sel_period = req_period[32*i +: 32];
        sel_con    = req_con[16*i +: 16];
      end
    end
    sel_illegal = ({29'd0, sel_ch} >= 32'(NUM_CH));
  end

  // Grant is only offered while idle; a reset cycle never accepts.
  assign req_ready = ((state_q == ST_IDLE) && !PRESET) ? gnt_oh : '0;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    ch_d     = ch_q;
    load_d   = load_q;
    period_d = period_q;
    con_d    = con_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          rr_d     = gnt_idx;
          gnt_d    = gnt_idx;
          ch_d     = sel_ch;
          load_d   = sel_load;
          period_d = sel_period;
          con_d    = sel_con;
          step_d   = 3'd0;
          err_d    = sel_illegal;
          // Illegal channel skips the bus entirely.
          state_d  = sel_illegal ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (step_q == LAST_STEP) begin
          // OVF (bit 3) is set by hardware, so it is excluded from the compare.
          err_d   = |((PRDATA[15:0] ^ con_q) & 16'hFFF7);
          state_d = ST_DONE;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      ch_q     <= '0;
      load_q   <= '0;
      period_q <= '0;
      con_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      ch_q     <= ch_d;
      load_q   <= load_d;
      period_q <= period_d;
      con_q    <= con_d;
      err_q    <= err_d;
    end
  end

  logic        apb_act;
  logic [1:0]  step_reg;
  logic        step_wr;
  logic [31:0] step_wdat;

  // Per-step register, direction and data; held constant across SETUP and ACCESS.
  always_comb begin
    step_reg  = REG_CON;
    step_wr   = 1'b1;
    step_wdat = '0;
    unique case (step_q)
      3'd0: step_wdat = {16'h0, con_q[15:1], 1'b0};
      3'd1: begin step_reg = REG_LOAD;   step_wdat = load_q;   end
      3'd2: begin step_reg = REG_PERIOD; step_wdat = period_q; end
      3'd3: begin step_reg = REG_COUNT;  step_wdat = '0;       end
      3'd4: step_wdat = {16'h0, con_q};
      default: step_wr = 1'b0;
    endcase
  end

  assign apb_act    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PSELPTC    = apb_act;
  assign PENABLE    = (state_q == ST_ACCESS);
  assign PWRITE     = apb_act && step_wr;
  assign PADDR      = apb_act ? {ch_q, step_reg, 2'b00} : 7'd0;
  assign PWDATA     = apb_act ? step_wdat : 32'd0;
  assign busy       = (state_q != ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_id    = (state_q == ST_DONE) ? gnt_q : 2'd0;
  assign done_err   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
module tb_pwm_cfg_sequencer;
  localparam int NUM_REQ = 2;
  localparam int NUM_CH  = 6;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_ready;
  logic [5:0]  req_ch;
  logic [63:0] req_load, req_period;
  logic [31:0] req_con;
  logic        done_valid, done_err, busy;
  logic [1:0]  done_id;
  logic        PSELPTC, PENABLE, PWRITE;
  logic [6:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  pwm_cfg_sequencer #(.NUM_REQ(NUM_REQ), .NUM_CH(NUM_CH)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch),
    .req_load(req_load), .req_period(req_period), .req_con(req_con),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .busy(busy),
    .PSELPTC(PSELPTC), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] load;
    logic [31:0] period;
    logic [15:0] con;
    bit          ovf;
    logic [15:0] flip;
  } req_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic        wr;
    logic [31:0] data;
  } apb_t;

  typedef struct {
    int   id;
    req_t r;
    bit   exp_err;
    int   exp_lat;
  } vec_t;

  int total = 0;
  int bad = 0;

  // PWM block model: register file plus OVF/bit-flip injection on CON reads.
  logic [31:0] pwm_reg [8][4];
  bit          cur_ovf;
  logic [15:0] cur_flip;
  logic [15:0] hi_junk;

  always_comb begin
    PRDATA = pwm_reg[PADDR[6:4]][PADDR[3:2]];
    if (PADDR[3:2] == 2'd3)
      PRDATA = {hi_junk, (pwm_reg[PADDR[6:4]][3][15:0] | (cur_ovf ? 16'h0008 : 16'h0000)) ^ cur_flip};
  end

  req_t rq0[$];
  req_t rq1[$];
  bit   inflight;
  int   grant_cyc, exp_done_cyc, exp_id;
  bit   exp_err;
  apb_t exp_apb[$];
  apb_t obs_apb[$];
  logic [1:0] rr_m;
  bit   setup_seen;
  apb_t setup_rec;
  int   last_lat, last_id;
  bit   last_err;
  bit   reset_hook, reset_fired, post_reset_chk;
  int   glog_id[$];
  int   glog_cyc[$];
  int   dlog_cyc[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic req_t mkreq(logic [2:0] ch, logic [31:0] ld, logic [31:0] pr,
                                 logic [15:0] con, bit ovf, logic [15:0] flip);
    req_t r;
    r.ch = ch; r.load = ld; r.period = pr; r.con = con; r.ovf = ovf; r.flip = flip;
    return r;
  endfunction

  function automatic vec_t mkvec(int id, req_t r, bit e, int lat);
    vec_t v;
    v.id = id; v.r = r; v.exp_err = e; v.exp_lat = lat;
    return v;
  endfunction

  function automatic void push_req(int id, req_t r);
    if (id == 0) rq0.push_back(r);
    else rq1.push_back(r);
  endfunction

  // Round-robin reference: first valid requester after the last granted one.
  function automatic int model_pick(logic [1:0] vld);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_m) + k) % NUM_REQ;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = '0; req_ch = '0; req_load = '0; req_period = '0; req_con = '0;
    if (rq0.size() > 0) begin
      req_valid[0] = 1'b1; req_ch[2:0] = rq0[0].ch; req_load[31:0] = rq0[0].load;
      req_period[31:0] = rq0[0].period; req_con[15:0] = rq0[0].con;
    end
    if (rq1.size() > 0) begin
      req_valid[1] = 1'b1; req_ch[5:3] = rq1[0].ch; req_load[63:32] = rq1[0].load;
      req_period[63:32] = rq1[0].period; req_con[31:16] = rq1[0].con;
    end
  endtask

  task automatic sample();
    int         pick;
    req_t       h;
    logic [6:0] base;
    logic [15:0] rb;
    chk("busy", busy, inflight);
    pick = (!inflight && !PRESET) ? model_pick(req_valid) : -1;
    chk("req_ready", req_ready, (pick < 0) ? 2'b00 : (2'b01 << pick));
    if (post_reset_chk) begin
      chk("rst_abort_psel", PSELPTC, 0);
      chk("rst_abort_busy", busy, 0);
      chk("rst_abort_done", done_valid, 0);
      post_reset_chk = 1'b0;
    end
    if (pick >= 0) begin
      h = (pick == 0) ? rq0.pop_front() : rq1.pop_front();
      rr_m = 2'(pick);
      inflight = 1'b1; grant_cyc = cyc; exp_id = pick;
      cur_ovf = h.ovf; cur_flip = h.flip; hi_junk = 16'($urandom);
      glog_id.push_back(pick); glog_cyc.push_back(cyc);
      obs_apb.delete(); exp_apb.delete();
      if (int'(h.ch) >= NUM_CH) begin
        exp_done_cyc = cyc + 1; exp_err = 1'b1;
      end else begin
        exp_done_cyc = cyc + 13;
        base = {h.ch, 4'h0};
        exp_apb.push_back('{base | 7'hC, 1'b1, {16'h0, h.con & 16'hFFFE}});
        exp_apb.push_back('{base | 7'h4, 1'b1, h.load});
        exp_apb.push_back('{base | 7'h8, 1'b1, h.period});
        exp_apb.push_back('{base, 1'b1, 32'h0});
        exp_apb.push_back('{base | 7'hC, 1'b1, {16'h0, h.con}});
        exp_apb.push_back('{base | 7'hC, 1'b0, 32'h0});
        rb = (h.con | (h.ovf ? 16'h0008 : 16'h0000)) ^ h.flip;
        exp_err = ((rb ^ h.con) & 16'hFFF7) != 16'h0;
      end
    end
    // APB protocol monitor and PWM register model update.
    if (PSELPTC && !PENABLE) begin
      setup_seen = 1'b1; setup_rec = '{PADDR, PWRITE, PWDATA};
    end else if (PSELPTC && PENABLE) begin
      chk("apb_setup_first", setup_seen, 1);
      chk("apb_stable", {PADDR, PWRITE, PWDATA}, setup_rec);
      obs_apb.push_back('{PADDR, PWRITE, PWDATA});
      if (PWRITE) pwm_reg[PADDR[6:4]][PADDR[3:2]] = PWDATA;
      setup_seen = 1'b0;
      if (reset_hook && PADDR[3:2] == 2'd2) begin
        PRESET = 1'b1; reset_hook = 1'b0; reset_fired = 1'b1;
        inflight = 1'b0; rr_m = 2'd0;
      end
    end else begin
      chk("apb_idle", {PENABLE, PWRITE, PADDR, PWDATA}, 0);
      setup_seen = 1'b0;
    end
    if (done_valid) begin
      if (!inflight) chk("spurious_done", done_valid, 0);
      else begin
        chk("done_cycle", cyc - grant_cyc, exp_done_cyc - grant_cyc);
        chk("done_id", done_id, exp_id);
        chk("done_err", done_err, exp_err);
        chk("apb_count", obs_apb.size(), exp_apb.size());
        for (int k = 0; k < exp_apb.size(); k++)
          if (k < obs_apb.size()) chk("apb_xfer", obs_apb[k], exp_apb[k]);
        last_lat = cyc - grant_cyc; last_id = done_id; last_err = done_err;
        dlog_cyc.push_back(cyc);
        inflight = 1'b0;
      end
    end else if (inflight && cyc >= exp_done_cyc) begin
      chk("done_missing", done_valid, 1);
      inflight = 1'b0;
    end
  endtask

  task automatic cycle_step();
    @(posedge PCLK);
    #1;
    if (reset_fired) begin
      PRESET = 1'b0; reset_fired = 1'b0; post_reset_chk = 1'b1;
    end
    drive();
    @(negedge PCLK);
    sample();
  endtask

  task automatic run_until_idle(int budget);
    int n;
    n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || inflight) && n < budget) begin
      cycle_step();
      n++;
    end
    chk("run_timeout", rq0.size() + rq1.size() + int'(inflight), 0);
    cycle_step();
    cycle_step();
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    inflight = 1'b0; rr_m = 2'd0; setup_seen = 1'b0;
    cycle_step();
    cycle_step();
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_apb", {PSELPTC, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    PRESET = 1'b0;
  endtask

  vec_t tbl[7];
  apb_t gold[6];
  req_t r;
  logic [15:0] fl;

  initial begin
    PRESET = 1'b1; reset_hook = 1'b0; reset_fired = 1'b0; post_reset_chk = 1'b0;
    cur_ovf = 1'b0; cur_flip = '0; hi_junk = '0; last_lat = -1; last_id = -1; last_err = 1'b0;
    for (int c = 0; c < 8; c++) for (int g = 0; g < 4; g++) pwm_reg[c][g] = '0;
    drive();

    tbl[0] = mkvec(0, mkreq(3'd2, 32'h40, 32'h10, 16'h0085, 1'b0, 16'h0000), 1'b0, 13);
    tbl[1] = mkvec(1, mkreq(3'd6, 32'h1, 32'h2, 16'h0001, 1'b0, 16'h0000), 1'b1, 1);
    tbl[2] = mkvec(0, mkreq(3'd1, 32'h5, 32'h9, 16'h0007, 1'b1, 16'h0000), 1'b0, 13);
    tbl[3] = mkvec(0, mkreq(3'd1, 32'h5, 32'h9, 16'h0007, 1'b1, 16'h0020), 1'b1, 13);
    tbl[4] = mkvec(1, mkreq(3'd7, 32'h3, 32'h4, 16'h00F0, 1'b0, 16'h0000), 1'b1, 1);
    tbl[5] = mkvec(1, mkreq(3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 16'hFFFF, 1'b0, 16'h0008), 1'b0, 13);
    tbl[6] = mkvec(0, mkreq(3'd0, 32'hFFFF_FFFF, 32'h0, 16'h1234, 1'b0, 16'h8000), 1'b1, 13);

    gold[0] = '{7'h2C, 1'b1, 32'h0000_0084};
    gold[1] = '{7'h24, 1'b1, 32'h0000_0040};
    gold[2] = '{7'h28, 1'b1, 32'h0000_0010};
    gold[3] = '{7'h20, 1'b1, 32'h0000_0000};
    gold[4] = '{7'h2C, 1'b1, 32'h0000_0085};
    gold[5] = '{7'h2C, 1'b0, 32'h0000_0000};

    apply_reset();

    // Single request: literal APB trace from the channel-2 example.
    push_req(0, tbl[0].r);
    run_until_idle(60);
    chk("ex_apb_count", obs_apb.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < obs_apb.size()) chk("ex_apb_xfer", obs_apb[k], gold[k]);
    chk("ex_done_lat", last_lat, 13);

    // Table of isolated requests.
    for (int i = 0; i < 7; i++) begin
      last_lat = -1; last_id = -1;
      push_req(tbl[i].id, tbl[i].r);
      run_until_idle(60);
      chk("tbl_err", last_err, tbl[i].exp_err);
      chk("tbl_lat", last_lat, tbl[i].exp_lat);
      chk("tbl_id", last_id, tbl[i].id);
    end

    // Both requesters busy from reset: r1 first, then strict alternation, one-cycle gaps.
    apply_reset();
    glog_id.delete(); glog_cyc.delete(); dlog_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      push_req(0, mkreq(3'd0, 32'(k + 1), 32'h100, 16'h0081, 1'b0, 16'h0));
      push_req(1, mkreq(3'd1, 32'(k + 7), 32'h200, 16'h0041, 1'b0, 16'h0));
    end
    run_until_idle(200);
    chk("alt_count", glog_id.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < glog_id.size()) chk("alt_order", glog_id[k], (k % 2 == 0) ? 1 : 0);
    for (int k = 1; k < 6; k++)
      if (k < glog_cyc.size() && k - 1 < dlog_cyc.size())
        chk("alt_gap", glog_cyc[k] - dlog_cyc[k - 1], 1);

    // Reset during the PERIOD write's ACCESS cycle, then fresh traffic.
    reset_hook = 1'b1;
    dlog_cyc.delete();
    push_req(0, mkreq(3'd3, 32'h11, 32'h22, 16'h0005, 1'b0, 16'h0));
    run_until_idle(60);
    chk("rst_no_done", dlog_cyc.size(), 0);
    glog_id.delete();
    push_req(0, mkreq(3'd4, 32'h33, 32'h44, 16'h0101, 1'b0, 16'h0));
    push_req(1, mkreq(3'd2, 32'h55, 32'h66, 16'h0201, 1'b0, 16'h0));
    run_until_idle(100);
    chk("rst_rr_first", (glog_id.size() > 0) ? glog_id[0] : -1, 1);
    chk("rst_fresh_err", last_err, 0);

    // Randomized traffic against the reference model.
    for (int rnd = 0; rnd < 12; rnd++) begin
      for (int q = 0; q < 2; q++) begin
        for (int n = $urandom_range(0, 3); n > 0; n--) begin
          case ($urandom_range(0, 3))
            0: fl = 16'h1 << $urandom_range(0, 15);
            1: fl = 16'h0008;
            default: fl = 16'h0;
          endcase
          r = mkreq(3'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom),
                    bit'($urandom_range(0, 1)), fl);
          push_req(q, r);
        end
      end
      run_until_idle(600);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
APB master that owns the configuration port of the 6-channel PWM/timer block and serialises channel-reprogramming requests from NUM_REQ independent requesters (round-robin). Each accepted request runs a fixed, glitch-safe write sequence to one PTC channel: disable, LOAD, PERIOD, COUNT clear, final CON. It then reads CON back for confirmation. Sits between firmware-side agents (CPU bridge, motor-control FSM) and the PWM block's PSELPTC/PADDR/PWDATA/PRDATA port.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
NUM_CH, 6, number of PTC channels present; channel index >= NUM_CH is illegal

Ports:
PCLK  input  1  clock
PRESET  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  request pending, one bit per requester
req_ready  output  NUM_REQ  one-hot accept strobe
req_ch  input  3*NUM_REQ  target channel, slice i for requester i
req_load  input  32*NUM_REQ  LOAD (duty/compare) value
req_period  input  32*NUM_REQ  PERIOD value
req_con  input  16*NUM_REQ  final CON value
done_valid  output  1  one-cycle completion pulse
done_id  output  2  requester index of completed request
done_err  output  1  1 = illegal channel or readback mismatch
busy  output  1  sequence in progress
PSELPTC  output  1  APB select to PWM block
PENABLE  output  1  APB enable
PWRITE  output  1  APB write
PADDR  output  7  [6:4] channel, [3:2] register, [1:0]=0
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data (combinational from PWM block)

Behaviour:
- Reset (PRESET=1 at PCLK edge): all outputs 0, FSM=IDLE, RR pointer=0. Reset mid-sequence aborts immediately, no done_valid, APB idle next cycle.
- Register map driven: COUNT 0x0, LOAD 0x4, PERIOD 0x8, CON 0xC within channel window ch*0x10.
- FSM: IDLE, SETUP, ACCESS, DONE; 3-bit step counter 0..5.
- IDLE: if any req_valid, grant first valid index starting at (last_grant+1) mod NUM_REQ; req_ready[g]=1 for that cycle only; capture ch/load/period/con. busy rises next cycle. Requester must hold fields stable while req_valid=1 and not ready.
- Illegal channel (captured ch >= NUM_CH): go straight to DONE; no APB traffic; done_err=1.
- Steps (each = SETUP cycle PSELPTC=1,PENABLE=0 then ACCESS cycle PSELPTC=1,PENABLE=1; no wait states, PWM block has no PREADY):
  0 write CON = {req_con[15:1],1'b0} with bit0 forced 0 (counter disabled)
  1 write LOAD = req_load
  2 write PERIOD = req_period
  3 write COUNT = 0
  4 write CON = req_con
  5 read CON; PWRITE=0, PWDATA=0; PRDATA[15:0] sampled on ACCESS edge.
- Readback compare: (PRDATA[15:0] ^ req_con) & 16'hFFF7 != 0 -> done_err=1 (bit3 OVF is hardware-set, masked); PRDATA[31:16] ignored.
- PADDR, PWRITE, PWDATA stable across SETUP and ACCESS of a step; all APB outputs 0 between sequences.
- ACCESS of step k goes directly to SETUP of step k+1 (no idle cycle).
- DONE: done_valid=1, done_id, done_err valid for exactly one cycle; busy=0 from next cycle; FSM returns to IDLE and may grant in the cycle after DONE.
- Latency: grant at cycle T, first SETUP T+1, step5 ACCESS T+12, done_valid T+13. Illegal channel: done_valid T+1.
- Requests arriving while busy wait; req_ready never asserted when busy.
- RR pointer updates to the granted index at grant; with NUM_REQ=1 arbitration degenerates to always-grant.

Test Plan:
- Single request r0: ch=2, load=0x40, period=0x10, con=0x0085 -> APB writes addr 0x2C=0x0084, 0x24=0x40, 0x28=0x10, 0x20=0, 0x2C=0x0085, read 0x2C; done_valid at grant+13, done_id=0, done_err=0; PWM_OUT2 toggles.
- Both requesters valid continuously, ch 0 and 1 -> grants alternate r1,r0,r1,... after reset (pointer 0 → r1 first); each gap between done_valid and next req_ready = 1 cycle.
- r1 ch=6 -> no PSELPTC activity, done_valid at grant+1, done_id=1, done_err=1.
- con=0x0007 with load_match forcing OVF set before readback -> CON reads 0x000F, done_err=0 (bit3 masked); force PRDATA bit5 flip via bench model -> done_err=1.
- PRESET asserted during step 2 ACCESS -> next cycle all APB outputs 0, busy=0, no done_valid; fresh request afterwards completes normally.
- APB protocol checker throughout: PENABLE only after one SETUP cycle, PADDR/PWDATA/PWRITE stable across the pair, req_ready one-hot and only when not busy.
